// File: rtl/wr_en_strobe_sched_pkg.sv
// Shared types and default widths for the wr/en strobe scheduler.
package wr_en_strobe_sched_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int TGL_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PARK = 2'd2
  } sched_state_t;

endpackage

// File: rtl/wr_en_strobe_sched_strobe_chan.sv
// One strobe channel: interval counter plus output flop, flipping the output
// each time the counter reaches the programmed period.
module strobe_chan
  import wr_en_strobe_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  input  logic             run,
  input  logic             park,
  output logic             q,
  output logic             flip_pulse
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             active;

  // While parking, only a channel still high keeps counting toward its final flip.
  always_comb begin
    cnt_next   = cnt + 1'b1;
    active     = (period != '0) && (run || (park && q));
    flip_pulse = active && (cnt_next == period);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (active) begin
      if (flip_pulse) begin
        cnt <= '0;
        q   <= ~q;
      end else begin
        cnt <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/wr_en_strobe_sched.sv
// Scheduler for the wr/en strobe pair: run/park FSM, latched configuration,
// wr toggle counter and the done pulse.
module wr_en_strobe_sched
  import wr_en_strobe_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TGL_W = TGL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] en_period,
  input  logic [TGL_W-1:0] num_tgl,
  output logic             wr,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [TGL_W-1:0] wr_tgl_cnt
);

  sched_state_t     state;
  sched_state_t     state_next;
  logic [CNT_W-1:0] wr_p;
  logic [CNT_W-1:0] en_p;
  logic [TGL_W-1:0] num_q;
  logic [TGL_W-1:0] tgl_inc;
  logic             clr;
  logic             run;
  logic             park;
  logic             wr_flip;
  logic             en_flip;
  logic             limit;
  logic             done_next;

  assign clr  = (state == IDLE) && start;
  assign run  = (state == RUN);
  assign park = (state == PARK);
  assign busy = (state != IDLE);

  strobe_chan #(.CNT_W(CNT_W)) u_wr_chan (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .period     (wr_p),
    .run        (run),
    .park       (park),
    .q          (wr),
    .flip_pulse (wr_flip)
  );

  strobe_chan #(.CNT_W(CNT_W)) u_en_chan (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .period     (en_p),
    .run        (run),
    .park       (park),
    .q          (en),
    .flip_pulse (en_flip)
  );

  // The limiting flip itself still happens; the FSM leaves RUN on that same edge.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    tgl_inc    = wr_tgl_cnt + 1'b1;
    limit      = (num_q != '0) && wr_flip && (tgl_inc == num_q);
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (stop || limit) state_next = PARK;
      PARK: begin
        if (!wr && !en) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_p       <= '0;
      en_p       <= '0;
      num_q      <= '0;
      wr_tgl_cnt <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (clr) begin
        wr_p       <= wr_period;
        en_p       <= en_period;
        num_q      <= num_tgl;
        wr_tgl_cnt <= '0;
      end else if (wr_flip) begin
        wr_tgl_cnt <= tgl_inc;
      end
    end
  end

  // en_flip is only consumed inside its channel; kept as a named port for symmetry.
  logic unused_en_flip;
  assign unused_en_flip = en_flip;

endmodule

// File: tb/tb_wr_en_strobe_sched.sv
// Self-checking bench: directed scenarios plus random traffic against an
// edge-schedule reference model (channel flips where edge index is a multiple of P).
module tb_wr_en_strobe_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  wr_period = '0;
  logic [7:0]  en_period = '0;
  logic [15:0] num_tgl = '0;
  logic        wr, en, busy, done;
  logic [15:0] wr_tgl_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: 0 idle, 1 run, 2 park
  int m_st = 0, m_e = 0, m_wp = 0, m_ep = 0, m_nt = 0, m_cnt = 0;
  bit m_wr = 0, m_en = 0, m_done = 0;

  wr_en_strobe_sched #(.CNT_W(8), .TGL_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .wr_period  (wr_period),
    .en_period  (en_period),
    .num_tgl    (num_tgl),
    .wr         (wr),
    .en         (en),
    .busy       (busy),
    .done       (done),
    .wr_tgl_cnt (wr_tgl_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit wrf, enf, lim;
    if (rst) begin
      m_st = 0; m_e = 0; m_wr = 0; m_en = 0; m_done = 0; m_cnt = 0;
      m_wp = 0; m_ep = 0; m_nt = 0;
      return;
    end
    m_done = 0;
    case (m_st)
      0: if (start) begin
        m_wp = int'(wr_period); m_ep = int'(en_period); m_nt = int'(num_tgl);
        m_e = 0; m_cnt = 0; m_wr = 0; m_en = 0; m_st = 1;
      end
      1: begin
        m_e++;
        wrf = (m_wp != 0) && (m_e % m_wp == 0);
        enf = (m_ep != 0) && (m_e % m_ep == 0);
        if (wrf) begin m_wr = !m_wr; m_cnt = (m_cnt + 1) % 65536; end
        if (enf) m_en = !m_en;
        lim = (m_nt != 0) && wrf && (m_cnt == m_nt);
        if (stop || lim) m_st = 2;
      end
      default: begin
        if (!m_wr && !m_en) begin
          m_st = 0; m_done = 1;
        end else begin
          m_e++;
          wrf = m_wr && (m_wp != 0) && (m_e % m_wp == 0);
          enf = m_en && (m_ep != 0) && (m_e % m_ep == 0);
          if (wrf) begin m_wr = 0; m_cnt = (m_cnt + 1) % 65536; end
          if (enf) m_en = 0;
        end
      end
    endcase
  endtask

  function automatic logic [19:0] obs_vec();
    return {wr, en, busy, done, wr_tgl_cnt};
  endfunction

  function automatic logic [19:0] exp_vec();
    return {m_wr, m_en, 1'(m_st != 0), m_done, 16'(m_cnt)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic begin_run(input int wp, input int ep, input int nt);
    wr_period = 8'(wp); en_period = 8'(ep); num_tgl = 16'(nt); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    vectors++;
    if (obs_vec() !== 20'h0) begin
      miscompares++;
      $display("[TB] FAIL reset: got %h want %h", obs_vec(), 20'h0);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_free_run();
    begin_run(2, 3, 0);
    for (int e = 1; e <= 9; e++) begin
      step();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL free_run e%0d: got %h want %h", e, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if ({wr, en, busy, wr_tgl_cnt} !== {3'b011, 16'd4}) begin
      miscompares++;
      $display("[TB] FAIL free_run_e9: got %h want %h", {wr, en, busy, wr_tgl_cnt}, {3'b011, 16'd4});
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 40 && (busy || done); i++) begin
      step();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL free_run_drain: got %h want %h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_auto_stop();
    int done_cnt = 0, done_edge = 0;
    begin_run(2, 3, 4);
    for (int e = 1; e <= 14; e++) begin
      step();
      if (done) begin done_cnt++; done_edge = e; end
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL auto_stop e%0d: got %h want %h", e, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (done_cnt !== 1 || done_edge !== 9 || wr_tgl_cnt !== 16'd4 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL auto_stop_done: got cnt=%0d edge=%0d tgl=%0d busy=%b want 1 9 4 0",
               done_cnt, done_edge, wr_tgl_cnt, busy);
    end
  endtask

  task automatic test_stop_high();
    int done_edge = 0;
    begin_run(2, 3, 0);
    for (int e = 1; e <= 10; e++) begin
      stop = (e == 3);
      step();
      if (done) done_edge = e;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL stop_high e%0d: got %h want %h", e, obs_vec(), exp_vec());
      end
    end
    stop = 1'b0;
    vectors++;
    if (done_edge !== 7 || wr_tgl_cnt !== 16'd2) begin
      miscompares++;
      $display("[TB] FAIL stop_high_done: got edge=%0d tgl=%0d want 7 2", done_edge, wr_tgl_cnt);
    end
  endtask

  task automatic test_disabled();
    begin_run(0, 1, 0);
    for (int e = 1; e <= 7; e++) begin
      step();
      vectors++;
      if (obs_vec() !== exp_vec() || wr !== 1'b0 || en !== 1'(e % 2)) begin
        miscompares++;
        $display("[TB] FAIL disabled e%0d: got %h want %h", e, obs_vec(), exp_vec());
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL disabled_drain: got %h want %h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_ignored();
    begin_run(2, 3, 0);
    for (int e = 1; e <= 8; e++) begin
      start = (e == 3);
      wr_period = (e == 3) ? 8'd1 : 8'd2;
      en_period = (e == 3) ? 8'd1 : 8'd3;
      step();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL ignored_start e%0d: got %h want %h", e, obs_vec(), exp_vec());
      end
    end
    start = 1'b0;
    vectors++;
    if (wr_tgl_cnt !== 16'd4) begin
      miscompares++;
      $display("[TB] FAIL ignored_cadence: got %0d want 4", wr_tgl_cnt);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 12; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL ignored_stop: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_run();
    begin_run(4, 3, 0);
    for (int e = 1; e <= 4; e++) step();
    vectors++;
    if (wr !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_wr: got %b want 1", wr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs_vec() !== 20'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_run: got %h want %h", obs_vec(), 20'h0);
      end
      step();
    end
    begin_run(2, 3, 0);
    for (int e = 1; e <= 4; e++) step();
    vectors++;
    if ({wr, en, busy, wr_tgl_cnt} !== {3'b011, 16'd2} || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL restart: got %h want %h", obs_vec(), exp_vec());
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      wr_period = 8'($urandom_range(0, 4));
      en_period = 8'($urandom_range(0, 4));
      num_tgl   = 16'($urandom_range(0, 5));
      step();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL random c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_auto_stop();
    test_stop_high();
    test_disabled();
    test_ignored();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
